// File: rtl/basic_gates_pkg.sv
// rtl/basic_gates_pkg.sv - shared types and width limits for basic_gates
package basic_gates_pkg;

  localparam int WIDTH_MIN = 1;
  localparam int WIDTH_MAX = 64;

  // The seven gate results for one bit pair.
  typedef struct packed {
    logic and_b;
    logic or_b;
    logic not_b;
    logic nand_b;
    logic nor_b;
    logic xor_b;
    logic xnor_b;
  } gate_bit_t;

  function automatic bit width_ok(input int w);
    return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
  endfunction

endpackage

// File: rtl/basic_gates_if.sv
// rtl/basic_gates_if.sv - operand/result bundle for basic_gates
interface basic_gates_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] and_out;
  logic [WIDTH-1:0] or_out;
  logic [WIDTH-1:0] not_a;
  logic [WIDTH-1:0] nand_out;
  logic [WIDTH-1:0] nor_out;
  logic [WIDTH-1:0] xor_out;
  logic [WIDTH-1:0] xnor_out;

  modport master (
    output a, b,
    input  and_out, or_out, not_a, nand_out, nor_out, xor_out, xnor_out
  );

  modport slave (
    input  a, b,
    output and_out, or_out, not_a, nand_out, nor_out, xor_out, xnor_out
  );
endinterface

// File: rtl/basic_gates_gate_slice.sv
// rtl/basic_gates_gate_slice.sv - seven gate results for a single bit pair
module gate_slice
  import basic_gates_pkg::*;
(
  input  logic      i_a,
  input  logic      i_b,
  output gate_bit_t o_res
);

  always_comb begin
    o_res.and_b  = i_a & i_b;
    o_res.or_b   = i_a | i_b;
    o_res.not_b  = ~i_a;
    o_res.nand_b = ~(i_a & i_b);
    o_res.nor_b  = ~(i_a | i_b);
    o_res.xor_b  = i_a ^ i_b;
    o_res.xnor_b = ~(i_a ^ i_b);
  end

endmodule

// File: rtl/basic_gates.sv
// rtl/basic_gates.sv - bitwise AND/OR/NOT/NAND/NOR/XOR/XNOR with optional output register
module basic_gates
  import basic_gates_pkg::*;
#(
  parameter int WIDTH   = 1,
  parameter bit OUT_REG = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] and_out,
  output logic [WIDTH-1:0] or_out,
  output logic [WIDTH-1:0] not_a,
  output logic [WIDTH-1:0] nand_out,
  output logic [WIDTH-1:0] nor_out,
  output logic [WIDTH-1:0] xor_out,
  output logic [WIDTH-1:0] xnor_out
);

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("basic_gates: WIDTH %0d outside 1..64", WIDTH);
  end

  gate_bit_t        w_bits [WIDTH];
  logic [WIDTH-1:0] w_and;
  logic [WIDTH-1:0] w_or;
  logic [WIDTH-1:0] w_not;
  logic [WIDTH-1:0] w_nand;
  logic [WIDTH-1:0] w_nor;
  logic [WIDTH-1:0] w_xor;
  logic [WIDTH-1:0] w_xnor;

  for (genvar i = 0; i < WIDTH; i++) begin : g_slice
    gate_slice u_slice (
      .i_a  (a[i]),
      .i_b  (b[i]),
      .o_res(w_bits[i])
    );
    assign w_and[i]  = w_bits[i].and_b;
    assign w_or[i]   = w_bits[i].or_b;
    assign w_not[i]  = w_bits[i].not_b;
    assign w_nand[i] = w_bits[i].nand_b;
    assign w_nor[i]  = w_bits[i].nor_b;
    assign w_xor[i]  = w_bits[i].xor_b;
    assign w_xnor[i] = w_bits[i].xnor_b;
  end

  if (OUT_REG) begin : g_reg
    logic [WIDTH-1:0] r_and;
    logic [WIDTH-1:0] r_or;
    logic [WIDTH-1:0] r_not;
    logic [WIDTH-1:0] r_nand;
    logic [WIDTH-1:0] r_nor;
    logic [WIDTH-1:0] r_xor;
    logic [WIDTH-1:0] r_xnor;

    // Reset clears every output, inverting ones included.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_and  <= '0;
        r_or   <= '0;
        r_not  <= '0;
        r_nand <= '0;
        r_nor  <= '0;
        r_xor  <= '0;
        r_xnor <= '0;
      end else begin
        r_and  <= w_and;
        r_or   <= w_or;
        r_not  <= w_not;
        r_nand <= w_nand;
        r_nor  <= w_nor;
        r_xor  <= w_xor;
        r_xnor <= w_xnor;
      end
    end

    assign and_out  = r_and;
    assign or_out   = r_or;
    assign not_a    = r_not;
    assign nand_out = r_nand;
    assign nor_out  = r_nor;
    assign xor_out  = r_xor;
    assign xnor_out = r_xnor;
  end else begin : g_comb
    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, clk, rst_n};

    assign and_out  = w_and;
    assign or_out   = w_or;
    assign not_a    = w_not;
    assign nand_out = w_nand;
    assign nor_out  = w_nor;
    assign xor_out  = w_xor;
    assign xnor_out = w_xnor;
  end

endmodule

// File: tb/tb_basic_gates.sv
// tb/tb_basic_gates.sv - scoreboard bench for basic_gates, combinational and registered builds
module tb_basic_gates;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst_c = 1'b1;
  always #5 clk = ~clk;

  basic_gates_if #(.WIDTH(1)) if_c1 ();
  basic_gates_if #(.WIDTH(8)) if_c8 ();
  basic_gates_if #(.WIDTH(8)) if_r ();

  basic_gates #(.WIDTH(1), .OUT_REG(1'b0)) u_c1 (
    .clk(clk), .rst_n(rst_c), .a(if_c1.a), .b(if_c1.b),
    .and_out(if_c1.and_out), .or_out(if_c1.or_out), .not_a(if_c1.not_a),
    .nand_out(if_c1.nand_out), .nor_out(if_c1.nor_out),
    .xor_out(if_c1.xor_out), .xnor_out(if_c1.xnor_out)
  );

  basic_gates #(.WIDTH(8), .OUT_REG(1'b0)) u_c8 (
    .clk(clk), .rst_n(rst_c), .a(if_c8.a), .b(if_c8.b),
    .and_out(if_c8.and_out), .or_out(if_c8.or_out), .not_a(if_c8.not_a),
    .nand_out(if_c8.nand_out), .nor_out(if_c8.nor_out),
    .xor_out(if_c8.xor_out), .xnor_out(if_c8.xnor_out)
  );

  basic_gates #(.WIDTH(8), .OUT_REG(1'b1)) u_reg (
    .clk(clk), .rst_n(rst_n), .a(if_r.a), .b(if_r.b),
    .and_out(if_r.and_out), .or_out(if_r.or_out), .not_a(if_r.not_a),
    .nand_out(if_r.nand_out), .nor_out(if_r.nor_out),
    .xor_out(if_r.xor_out), .xnor_out(if_r.xnor_out)
  );

  int errors = 0;
  int checks = 0;

  logic [55:0] q_c1 [$];
  logic [55:0] q_c8 [$];
  logic [55:0] q_r  [$];
  event        comb_ev;
  logic [55:0] last_exp;

  localparam logic [55:0] BIT0_MASK = {7{8'h01}};

  // Reference: per-bit truth table, columns indexed by {a,b}; result packed
  // as [6]=xnor [5]=xor [4]=nor [3]=nand [2]=not_a [1]=or [0]=and.
  function automatic logic [55:0] model(input logic [7:0] a, input logic [7:0] b);
    logic [3:0]      tt [7];
    logic [6:0][7:0] r;
    tt = '{4'b1000, 4'b1110, 4'b0011, 4'b0111, 4'b0001, 4'b0110, 4'b1001};
    for (int g = 0; g < 7; g++)
      for (int i = 0; i < 8; i++)
        r[g][i] = tt[g][{a[i], b[i]}];
    return r;
  endfunction

  function automatic logic [55:0] act_c1();
    return {7'd0, if_c1.xnor_out, 7'd0, if_c1.xor_out, 7'd0, if_c1.nor_out,
            7'd0, if_c1.nand_out, 7'd0, if_c1.not_a, 7'd0, if_c1.or_out,
            7'd0, if_c1.and_out};
  endfunction

  function automatic logic [55:0] act_c8();
    return {if_c8.xnor_out, if_c8.xor_out, if_c8.nor_out, if_c8.nand_out,
            if_c8.not_a, if_c8.or_out, if_c8.and_out};
  endfunction

  function automatic logic [55:0] act_r();
    return {if_r.xnor_out, if_r.xor_out, if_r.nor_out, if_r.nand_out,
            if_r.not_a, if_r.or_out, if_r.and_out};
  endfunction

  task automatic chk(input string name, input logic [55:0] act, input logic [55:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %014h expected %014h at %0t", name, act, exp, $time);
    end
  endtask

  // Combinational scoreboard consumer.
  initial begin
    forever begin
      @(comb_ev);
      while (q_c1.size() > 0) chk("comb_w1", act_c1(), q_c1.pop_front());
      while (q_c8.size() > 0) chk("comb_w8", act_c8(), q_c8.pop_front());
    end
  end

  // Registered scoreboard consumer: one expected entry per captured edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q_r.size() > 0) chk("reg_out", act_r(), q_r.pop_front());
    end
  end

  task automatic drive_comb(input logic [7:0] a8, input logic [7:0] b8);
    if_c1.a = a8[0];
    if_c1.b = b8[0];
    if_c8.a = a8;
    if_c8.b = b8;
    q_c1.push_back(model(a8, b8) & BIT0_MASK);
    q_c8.push_back(model(a8, b8));
    #1 ->comb_ev;
    #9;
  endtask

  initial begin
    logic [7:0] ra, rb;
    bit         want_rst;

    if_r.a = 8'hFF;
    if_r.b = 8'hFF;
    if_c1.a = 1'b0;
    if_c1.b = 1'b0;
    if_c8.a = 8'h00;
    if_c8.b = 8'h00;
    #1 chk("reset_state", act_r(), 56'd0);

    for (int k = 0; k < 4; k++) begin
      ra = {7'd0, k[1]};
      rb = {7'd0, k[0]};
      drive_comb(ra, rb);
    end
    drive_comb(8'hF0, 8'hCC);
    chk("w8_F0_CC", act_c8(), {8'hC3, 8'h3C, 8'h03, 8'h3F, 8'h0F, 8'hFC, 8'hC0});
    for (int k = 0; k < 6; k++) drive_comb(8'($urandom), 8'($urandom));

    // clk/rst_n must not disturb the combinational build.
    for (int k = 0; k < 8; k++) begin
      rst_c = 1'($urandom);
      drive_comb(8'h01, 8'h00);
      #($urandom_range(1, 7));
    end
    rst_c = 1'b1;

    @(negedge clk);
    #1 chk("reset_hold_a1b1", act_r(), 56'd0);
    last_exp = 56'd0;

    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      #1 chk("hold_between_edges", act_r(), last_exp);
      want_rst = (n >= 12 && n <= 14) || (n == 25);
      ra = (n == 0) ? 8'hFF : 8'($urandom);
      rb = (n == 0) ? 8'hFF : 8'($urandom);
      if (n == 1) begin
        ra = 8'h00;
        rb = 8'h01;
      end
      if_r.a = ra;
      if_r.b = rb;
      #1;
      if (want_rst) begin
        rst_n = 1'b0;
        #1 chk("async_reset", act_r(), 56'd0);
      end else begin
        rst_n = 1'b1;
        #1;
      end
      if ((n % 4 == 2) && !want_rst) begin
        ra = 8'($urandom);
        rb = 8'($urandom);
        if_r.a = ra;
        if_r.b = rb;
        #1 chk("mid_cycle_hold", act_r(), last_exp);
      end
      last_exp = want_rst ? 56'd0 : model(ra, rb);
      q_r.push_back(last_exp);
    end

    repeat (3) @(negedge clk);
    chk("drain_reg", 56'(q_r.size()), 56'd0);
    chk("drain_comb", 56'(q_c1.size() + q_c8.size()), 56'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
